chunked_seq_adder: RTL and testbench
====================================

// Module: chunked_seq_adder
// PURPOSE
//   Multi-cycle N-bit adder/subtractor. Consumes CHUNK bits per clock, LSB first,
//   and ripples the carry through a registered carry flop. Sits behind a valid/ready
//   handshake on both sides for area-constrained datapaths.
//   Parametrised successor of the combinational N-bit adder: adds sub mode,
//   backpressure and cycle-level sequencing.
// PARAMETERS
//   N      8   operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  2   bits processed per cycle; 1 <= CHUNK <= N
//   STEPS  (derived localparam) N/CHUNK, compute cycles per operation
// PORTS
//   clk        in   1  rising-edge clock, the only clock
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  block can accept; = (state==IDLE)
//   A          in   N  operand A
//   B          in   N  operand B
//   Cin        in   1  carry-in (sub=0) / borrow-in (sub=1)
//   sub        in   1  0: add, 1: subtract
//   out_valid  out  1  result valid
//   out_ready  in   1  consumer accepts result
//   Sum        out  N  result
//   Cout       out  1  carry-out; in sub mode 1 = no borrow
//   ovf        out  1  signed overflow (present only with CHUNK_ADDER_OVF_EN)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, Sum=0, Cout=0, out_valid=0, ovf=0,
//     step counter=0. in_ready reads 1 while in reset. Reset mid-RUN/DONE aborts
//     the operation; no result is produced.
//   - Arithmetic:
//       sub=0: {Cout,Sum} = A + B + Cin
//       sub=1: {Cout,Sum} = A + ~B + ~Cin, i.e. A - B - Cin (mod 2^N)
//     All sums are N+1 bits wide; no truncation other than mod 2^N on Sum.
//   - FSM:
//       IDLE: in_ready=1. On in_valid, latch A, B^{N{sub}}, sub, carry <= Cin^sub,
//             cnt <= 0; go to RUN.
//       RUN:  each cycle add chunk cnt ({carry, chunk} = a_chunk + b_chunk + carry);
//             write Sum[cnt*CHUNK +: CHUNK]; cnt++. After the chunk with
//             cnt==STEPS-1: Cout <= final carry, out_valid <= 1, go to DONE.
//       DONE: hold Sum/Cout/ovf stable while out_valid=1 && out_ready=0.
//             On out_ready: out_valid <= 0, go to IDLE.
//   - Latency: operands accepted at edge k; out_valid rises at edge k+STEPS.
//   - Throughput: in_ready is low in RUN and DONE. No same-cycle accept on DONE->IDLE,
//     so back-to-back ops take STEPS+2 cycles minimum with out_ready held high.
//   - in_valid while in_ready=0 is ignored; operand ports are not sampled.
//   - CHUNK==N degenerates to STEPS=1 (single RUN cycle).
//   - Sum holds its last result after DONE until the next op overwrites it.
// CONFIGURATION
//   CHUNK_ADDER_OVF_EN defined:
//     port ovf exists; set in the final RUN cycle to
//     carry_into_MSB ^ carry_out_of_MSB (of the effective addition);
//     valid with out_valid; reset to 0.
//   CHUNK_ADDER_OVF_EN undefined:
//     port ovf and its logic are absent; all other behaviour is identical.
// TESTING (N=8, CHUNK=2 unless stated)
//   1. A=15, B=1, Cin=0, sub=0 -> Sum=16, Cout=0; out_valid exactly 4 cycles after accept.
//   2. A=255, B=1, Cin=0 -> Sum=0, Cout=1. A=170, B=85, Cin=1 -> Sum=0, Cout=1.
//   3. sub=1: A=5, B=3, Cin=0 -> Sum=2, Cout=1. A=3, B=5, Cin=0 -> Sum=254, Cout=0.
//      A=5, B=3, Cin=1 -> Sum=1, Cout=1.
//   4. Backpressure: out_ready=0 for 5 cycles -> Sum/Cout stable, in_ready=0, and
//      in_valid pulses ignored; then out_ready=1 -> IDLE; next op accepted 1 cycle later.
//   5. Reset: rst_n low at RUN cycle 2 -> immediately out_valid=0, Sum=0, in_ready=1;
//      no stale result after release.
//   6. OVF_EN: A=127, B=1 -> Sum=128, ovf=1; sub with A=128, B=1 -> Sum=127, ovf=1.
//      Repeat 1-3 with N=16, CHUNK=4 (latency 4) and CHUNK=N (latency 1).

Source files
------------

// File: rtl/chunked_seq_adder.sv
// Sequential N-bit adder/subtractor: CHUNK bits per cycle, LSB first, carry rippled through a flop.
// Optional signed-overflow output `ovf` is built when CHUNK_ADDER_OVF_EN is defined.
module chunked_seq_adder #(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout
`ifdef CHUNK_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int STEPS = N / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic           r_out_valid;
  logic [CW-1:0]  r_cnt;
  logic [CHUNK:0] w_chunk;
  logic           w_last;
`ifdef CHUNK_ADDER_OVF_EN
  logic           r_ovf;
`endif

  // Operands shift right each RUN cycle, so the active chunk is always in the low bits.
  assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_cnt == CW'(STEPS - 1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
`ifdef CHUNK_ADDER_OVF_EN
  assign ovf       = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
`ifdef CHUNK_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + ~Cin; the inversion is folded in at capture.
            r_a     <= A;
            r_b     <= B ^ {N{sub}};
            r_carry <= Cin ^ sub;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_chunk[CHUNK];
          for (int s = 0; s < STEPS; s++) begin
            if (r_cnt == CW'(s)) r_sum[s*CHUNK +: CHUNK] <= w_chunk[CHUNK-1:0];
          end
          if (w_last) begin
            r_cnt       <= '0;
            r_cout      <= w_chunk[CHUNK];
            r_out_valid <= 1'b1;
`ifdef CHUNK_ADDER_OVF_EN
            // a^b^sum at the MSB recovers the carry into it.
            r_ovf       <= r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk[CHUNK-1] ^ w_chunk[CHUNK];
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder: scoreboard of model results checked with immediate assertions.
module tb_chunked_seq_adder;
  localparam int N      = 8;
  localparam int CHUNK  = 2;
  localparam int STEPS  = N / CHUNK;
  localparam int N2     = 16;
  localparam int CHUNK2 = 4;
  localparam int STEPS2 = N2 / CHUNK2;
  localparam int N3     = 8;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic Cin = 1'b0;
  logic sub = 1'b0;
  logic out_ready = 1'b1;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic in_ready, out_valid, Cout;
  logic [N-1:0] Sum;

  logic in_valid2 = 1'b0;
  logic Cin2 = 1'b0;
  logic sub2 = 1'b0;
  logic out_ready2 = 1'b1;
  logic [N2-1:0] A2 = '0;
  logic [N2-1:0] B2 = '0;
  logic in_ready2, out_valid2, Cout2;
  logic [N2-1:0] Sum2;

  logic in_valid3 = 1'b0;
  logic Cin3 = 1'b0;
  logic sub3 = 1'b0;
  logic out_ready3 = 1'b1;
  logic [N3-1:0] A3 = '0;
  logic [N3-1:0] B3 = '0;
  logic in_ready3, out_valid3, Cout3;
  logic [N3-1:0] Sum3;
`ifdef CHUNK_ADDER_OVF_EN
  logic ovf, ovf2, ovf3;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  chunked_seq_adder #(.N(N), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout)
`ifdef CHUNK_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  chunked_seq_adder #(.N(N2), .CHUNK(CHUNK2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(A2), .B(B2), .Cin(Cin2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2), .Sum(Sum2), .Cout(Cout2)
`ifdef CHUNK_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  chunked_seq_adder #(.N(N3), .CHUNK(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .A(A3), .B(B3), .Cin(Cin3), .sub(sub3),
    .out_valid(out_valid3), .out_ready(out_ready3), .Sum(Sum3), .Cout(Cout3)
`ifdef CHUNK_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic s);
    exp_t         e;
    logic [N-1:0] be;
    logic         c;
    logic [N:0]   t;
    be = s ? ~b : b;
    c  = s ? ~cin : cin;
    t  = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, c};
    e.sum  = t[N-1:0];
    e.cout = t[N];
    e.ovf  = (a[N-1] == be[N-1]) && (t[N-1] != a[N-1]);
    return e;
  endfunction

  // One operation on dut; hold>0 keeps out_ready low that many cycles with junk in_valid pulses.
  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic cin, input logic s, input int hold);
    int   lat;
    exp_t e;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    A = a; B = b; Cin = cin; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(a, b, cin, s));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(STEPS));
    chk({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, ".sum"}, 32'(Sum), 32'(e.sum));
    chk({tag, ".cout"}, 32'(Cout), 32'(e.cout));
`ifdef CHUNK_ADDER_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    for (int i = 0; i < hold; i++) begin
      A = N'($urandom); B = N'($urandom); Cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".hold_sum"}, 32'(Sum), 32'(e.sum));
      chk({tag, ".hold_cout"}, 32'(Cout), 32'(e.cout));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op2(input string tag, input logic [N2-1:0] a, input logic [N2-1:0] b,
                     input logic cin, input logic s, input logic [N2:0] exp);
    int lat;
    A2 = a; B2 = b; Cin2 = cin; sub2 = s; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(STEPS2));
    chk({tag, ".result"}, 32'({Cout2, Sum2}), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic op3(input string tag, input logic [N3-1:0] a, input logic [N3-1:0] b,
                     input logic cin, input logic s, input logic [N3:0] exp);
    int lat;
    A3 = a; B3 = b; Cin3 = cin; sub3 = s; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    lat = 0;
    while (!out_valid3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd1);
    chk({tag, ".result"}, 32'({Cout3, Sum3}), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;

    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(Sum), 32'd0);
    chk("rst.cout", 32'(Cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("add15_1", 8'd15, 8'd1, 1'b0, 1'b0, 0);
    op("add255_1", 8'd255, 8'd1, 1'b0, 1'b0, 0);
    op("add170_85c", 8'd170, 8'd85, 1'b1, 1'b0, 0);
    op("sub5_3", 8'd5, 8'd3, 1'b0, 1'b1, 0);
    op("sub3_5", 8'd3, 8'd5, 1'b0, 1'b1, 0);
    op("sub5_3b", 8'd5, 8'd3, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      op("rand", N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    op("bp", 8'd100, 8'd27, 1'b0, 1'b0, 5);
    op("after_bp", 8'd200, 8'd100, 1'b1, 1'b0, 0);

`ifdef CHUNK_ADDER_OVF_EN
    op("ovf_add", 8'd127, 8'd1, 1'b0, 1'b0, 0);
    op("ovf_sub", 8'd128, 8'd1, 1'b0, 1'b1, 0);
    op("no_ovf", 8'd100, 8'd20, 1'b0, 1'b0, 0);
`endif

    A = 8'h55; B = 8'h22; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.sum", 32'(Sum), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst.no_stale", 32'(seen), 32'd0);
    op("post_rst", 8'd9, 8'd7, 1'b0, 1'b1, 0);

    op2("w16.add15_1", 16'd15, 16'd1, 1'b0, 1'b0, 17'h00010);
    op2("w16.wrap", 16'hFFFF, 16'd1, 1'b0, 1'b0, 17'h10000);
    op2("w16.sub3_5", 16'd3, 16'd5, 1'b0, 1'b1, 17'h0FFFE);
    op2("w16.sub5_3b", 16'd5, 16'd3, 1'b1, 1'b1, 17'h10001);

    op3("c8.add15_1", 8'd15, 8'd1, 1'b0, 1'b0, 9'h010);
    op3("c8.add170_85c", 8'd170, 8'd85, 1'b1, 1'b0, 9'h100);
    op3("c8.sub3_5", 8'd3, 8'd5, 1'b0, 1'b1, 9'h0FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
